main_memory: RTL and testbench

Backing-store RAM model that sits directly downstream of the 4-entry LRU cache. It answers the cache's memory-side requests (address, shared bidirectional data bus, rw, ce) with a parameterized read latency. It drives the shared bus only during its read-data cycle. A single-cycle ready pulse marks completion so the cache controller can time its fill and write-back states.

---
 rtl/main_memory.sv | 154 +++++++++++++++
 tb/tb_main_memory.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory.sv
// main_memory
//   Backing-store RAM behind the 4-entry LRU cache. It accepts one request at a
//   time from IDLE. A write commits on the accepting edge and is acknowledged one
//   cycle later. A read waits LATENCY cycles and then drives the shared bus for
//   exactly one cycle. rdy pulses for one cycle at the end of each request.
//
// Parameters
//   d_width    data bus width
//   a_width    address width, depth = 2**a_width words
//   LATENCY    read wait cycles before data is driven (1..15)
//   PROT_LIMIT first writable address when write protection is enabled
//
// Ports
//   clk     rising-edge clock
//   clr     synchronous active-high reset; clears state and every memory word
//   addr    request address, latched on accept
//   data    shared bus; sampled on write accept, driven only in RD_DRIVE
//   rw      1 = read, 0 = write
//   ce      request strobe, only honoured in IDLE
//   rdy     one-cycle completion pulse
//   busy    high whenever the FSM is not in IDLE
//   wr_err  one-cycle pulse when a protected write is dropped
//
// Optional feature
//   MAIN_MEM_WR_PROTECT_EN: when defined, writes below PROT_LIMIT are dropped and
//   flagged on wr_err. When it is undefined, every write commits and wr_err stays 0.
//
// state    | meaning
// IDLE     | waiting for ce
// RD_WAIT  | read latency countdown
// RD_DRIVE | read data on bus, rdy high
// WR_ACK   | write acknowledged, rdy high

module main_memory #(
  parameter int d_width    = 8,
  parameter int a_width    = 8,
  parameter int LATENCY    = 2,
  parameter int PROT_LIMIT = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [a_width-1:0] addr,
  inout  wire  [d_width-1:0] data,
  input  logic               rw,
  input  logic               ce,
  output logic               rdy,
  output logic               busy,
  output logic               wr_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_WAIT  = 2'd1;
  localparam logic [1:0] RD_DRIVE = 2'd2;
  localparam logic [1:0] WR_ACK   = 2'd3;

  localparam int         DEPTH  = 2 ** a_width;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [a_width-1:0] addr_q, addr_d;
  logic               rw_q, rw_d;
  logic [d_width-1:0] rd_q, rd_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;
  logic               wr_err_q, wr_err_d;
  logic               we;
  logic               wr_blocked;

  logic [d_width-1:0] mem_q [DEPTH];

`ifdef MAIN_MEM_WR_PROTECT_EN
  assign wr_blocked = (32'(addr) < 32'(PROT_LIMIT));
`else
  assign wr_blocked = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    rd_d     = rd_q;
    rdy_d    = 1'b0;
    wr_err_d = 1'b0;
    we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ce) begin
          addr_d = addr;
          rw_d   = rw;
          if (rw) begin
            state_d = RD_WAIT;
            cnt_d   = LAT_M1;
          end else begin
            state_d  = WR_ACK;
            rdy_d    = 1'b1;
            we       = ~wr_blocked;
            wr_err_d = wr_blocked;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Data is captured from the latched address as RD_DRIVE is entered,
          // so later changes on addr have no effect on this read.
          state_d = RD_DRIVE;
          rdy_d   = 1'b1;
          rd_d    = mem_q[addr_q];
        end
      end
      RD_DRIVE: state_d = IDLE;
      WR_ACK:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      rd_q     <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      rd_q     <= rd_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      wr_err_q <= wr_err_d;
      if (we) begin
        mem_q[addr] <= data;
      end
    end
  end

  assign data   = (state_q == RD_DRIVE) ? rd_q : {d_width{1'bz}};
  assign rdy    = rdy_q;
  assign busy   = busy_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory
//   Directed bench for main_memory (LATENCY=2). The data bus carries pullups,
//   so a released bus reads 8'hFF. Every value driven by the memory in these
//   tests differs from 8'hFF, which lets the bench tell a driven bus from a
//   released one.

module tb_main_memory;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] addr;
  logic       rw;
  logic       ce;
  logic [7:0] tb_dq;
  logic       tb_oe;
  wire  [7:0] data;
  logic       rdy;
  logic       busy;
  logic       wr_err;

  int n_pass  = 0;
  int n_total = 0;

  assign data = tb_oe ? tb_dq : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup pu (data[g]);
  end

  always #5 clk = ~clk;

  main_memory #(
    .d_width   (8),
    .a_width   (8),
    .LATENCY   (LAT),
    .PROT_LIMIT(16)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .addr  (addr),
    .data  (data),
    .rw    (rw),
    .ce    (ce),
    .rdy   (rdy),
    .busy  (busy),
    .wr_err(wr_err)
  );

  // Issues a read and reports the results. lat is the number of negedges after
  // the accept edge at which rdy was first seen, or -1 on timeout. addr is moved
  // to a_after and ce is dropped right after the accept edge.
  task automatic do_read(input logic [7:0] a, input logic [7:0] a_after,
                         output int lat, output logic [7:0] rd,
                         output logic busy_ok, output logic z_ok,
                         output logic idle_ok);
    addr = a; rw = 1'b1; ce = 1'b1; tb_oe = 1'b0;
    @(posedge clk);
    lat = -1; rd = 8'h00; busy_ok = 1'b1; z_ok = 1'b1;
    for (int j = 0; j < 20 && lat < 0; j++) begin
      @(negedge clk); #1;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (rdy === 1'b1) begin
        lat = j;
        rd  = data;
      end else if (data !== 8'hFF) begin
        z_ok = 1'b0;
      end
      if (j == 0) begin
        addr = a_after;
        ce   = 1'b0;
      end
    end
    @(negedge clk); #1;
    idle_ok = (rdy === 1'b0) && (busy === 1'b0);
    if (data !== 8'hFF) z_ok = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] v,
                          output logic r, output logic err, output logic busy1,
                          output logic z_ok, output logic idle_ok);
    addr = a; rw = 1'b0; ce = 1'b1; tb_dq = v; tb_oe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_oe = 1'b0; ce = 1'b0;
    #1;
    r     = rdy;
    err   = wr_err;
    busy1 = busy;
    z_ok  = (data === 8'hFF);
    @(negedge clk); #1;
    idle_ok = (rdy === 1'b0) && (busy === 1'b0);
    if (data !== 8'hFF) z_ok = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [7:0] rd; logic bo, zo, io;
    clr = 1'b1; ce = 1'b0; rw = 1'b0; addr = 8'h00; tb_oe = 1'b0; tb_dq = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_total++; if (rdy !== 1'b0) $display("FAIL reset_rdy: got %b exp 0", rdy); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
    n_total++; if (wr_err !== 1'b0) $display("FAIL reset_wr_err: got %b exp 0", wr_err); else n_pass++;
    n_total++; if (data !== 8'hFF) $display("FAIL reset_bus_released: got %h exp ff", data); else n_pass++;
    clr = 1'b0;
    do_read(8'h20, 8'h20, lat, rd, bo, zo, io);
    n_total++; if (lat !== LAT) $display("FAIL reset_read_lat: got %0d exp %0d", lat, LAT); else n_pass++;
    n_total++; if (rd !== 8'h00) $display("FAIL reset_read_data: got %h exp 00", rd); else n_pass++;
    n_total++; if (zo !== 1'b1) $display("FAIL reset_read_bus_z: got %b exp 1", zo); else n_pass++;
    n_total++; if (io !== 1'b1) $display("FAIL reset_read_idle: got %b exp 1", io); else n_pass++;
  endtask

  task automatic test_write_read();
    int lat; logic [7:0] rd; logic r, e, b1, bo, zo, io;
    do_write(8'h40, 8'hA5, r, e, b1, zo, io);
    n_total++; if (r !== 1'b1) $display("FAIL wr_rdy: got %b exp 1", r); else n_pass++;
    n_total++; if (b1 !== 1'b1) $display("FAIL wr_busy: got %b exp 1", b1); else n_pass++;
    n_total++; if (e !== 1'b0) $display("FAIL wr_err_clear: got %b exp 0", e); else n_pass++;
    n_total++; if (zo !== 1'b1) $display("FAIL wr_bus_z: got %b exp 1", zo); else n_pass++;
    n_total++; if (io !== 1'b1) $display("FAIL wr_idle: got %b exp 1", io); else n_pass++;
    do_read(8'h40, 8'h40, lat, rd, bo, zo, io);
    n_total++; if (lat !== LAT) $display("FAIL rd_lat: got %0d exp %0d", lat, LAT); else n_pass++;
    n_total++; if (rd !== 8'hA5) $display("FAIL rd_data: got %h exp a5", rd); else n_pass++;
    n_total++; if (bo !== 1'b1) $display("FAIL rd_busy: got %b exp 1", bo); else n_pass++;
    n_total++; if (zo !== 1'b1) $display("FAIL rd_bus_z: got %b exp 1", zo); else n_pass++;
    n_total++; if (io !== 1'b1) $display("FAIL rd_idle: got %b exp 1", io); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int lat; logic [7:0] rd; logic bo, zo, io;
    addr = 8'h40; rw = 1'b1; ce = 1'b1; tb_oe = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    addr = 8'h41; rw = 1'b0; tb_dq = 8'h11; tb_oe = 1'b1; ce = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    tb_oe = 1'b0; ce = 1'b0;
    n_total++; if (rdy !== 1'b0) $display("FAIL ign_rdy_early: got %b exp 0", rdy); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (rdy !== 1'b1) $display("FAIL ign_rdy: got %b exp 1", rdy); else n_pass++;
    n_total++; if (data !== 8'hA5) $display("FAIL ign_rd_data: got %h exp a5", data); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (busy !== 1'b0) $display("FAIL ign_idle_busy: got %b exp 0", busy); else n_pass++;
    do_read(8'h41, 8'h41, lat, rd, bo, zo, io);
    n_total++; if (rd !== 8'h00) $display("FAIL ign_not_written: got %h exp 00", rd); else n_pass++;
  endtask

  task automatic test_latched_addr();
    int lat; logic [7:0] rd; logic bo, zo, io;
    do_read(8'h40, 8'h55, lat, rd, bo, zo, io);
    n_total++; if (lat !== LAT) $display("FAIL latch_lat: got %0d exp %0d", lat, LAT); else n_pass++;
    n_total++; if (rd !== 8'hA5) $display("FAIL latch_data: got %h exp a5", rd); else n_pass++;
    n_total++; if (io !== 1'b1) $display("FAIL latch_single_rdy: got %b exp 1", io); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] rd; logic r, e, b1, bo, zo, io;
    do_write(8'h80, 8'h5A, r, e, b1, zo, io);
    do_read(8'h80, 8'h80, lat, rd, bo, zo, io);
    n_total++; if (rd !== 8'h5A) $display("FAIL b2b_raw: got %h exp 5a", rd); else n_pass++;
    n_total++; if (lat !== LAT) $display("FAIL b2b_lat: got %0d exp %0d", lat, LAT); else n_pass++;
    do_write(8'h81, 8'hC3, r, e, b1, zo, io);
    n_total++; if (r !== 1'b1) $display("FAIL b2b_wr_rdy: got %b exp 1", r); else n_pass++;
    do_write(8'hFF, 8'h96, r, e, b1, zo, io);
    do_read(8'h80, 8'h80, lat, rd, bo, zo, io);
    n_total++; if (rd !== 8'h5A) $display("FAIL b2b_keep_80: got %h exp 5a", rd); else n_pass++;
    do_read(8'h81, 8'h81, lat, rd, bo, zo, io);
    n_total++; if (rd !== 8'hC3) $display("FAIL b2b_rd_81: got %h exp c3", rd); else n_pass++;
    do_read(8'hFF, 8'hFF, lat, rd, bo, zo, io);
    n_total++; if (rd !== 8'h96) $display("FAIL b2b_top_addr: got %h exp 96", rd); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int lat; logic [7:0] rd; logic bo, zo, io;
    addr = 8'h40; rw = 1'b1; ce = 1'b1; tb_oe = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    ce = 1'b0; clr = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    n_total++; if (rdy !== 1'b0) $display("FAIL midclr_rdy: got %b exp 0", rdy); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL midclr_busy: got %b exp 0", busy); else n_pass++;
    n_total++; if (data !== 8'hFF) $display("FAIL midclr_bus_z: got %h exp ff", data); else n_pass++;
    clr = 1'b0;
    do_read(8'h40, 8'h40, lat, rd, bo, zo, io);
    n_total++; if (rd !== 8'h00) $display("FAIL midclr_mem_cleared: got %h exp 00", rd); else n_pass++;
    n_total++; if (lat !== LAT) $display("FAIL midclr_read_lat: got %0d exp %0d", lat, LAT); else n_pass++;
  endtask

  task automatic test_protect();
    int lat; logic [7:0] rd; logic r, e, b1, bo, zo, io;
    do_write(8'h05, 8'h77, r, e, b1, zo, io);
    n_total++; if (r !== 1'b1) $display("FAIL prot_low_rdy: got %b exp 1", r); else n_pass++;
`ifdef MAIN_MEM_WR_PROTECT_EN
    n_total++; if (e !== 1'b1) $display("FAIL prot_low_err: got %b exp 1", e); else n_pass++;
    do_read(8'h05, 8'h05, lat, rd, bo, zo, io);
    n_total++; if (rd !== 8'h00) $display("FAIL prot_low_data: got %h exp 00", rd); else n_pass++;
`else
    n_total++; if (e !== 1'b0) $display("FAIL prot_low_err: got %b exp 0", e); else n_pass++;
    do_read(8'h05, 8'h05, lat, rd, bo, zo, io);
    n_total++; if (rd !== 8'h77) $display("FAIL prot_low_data: got %h exp 77", rd); else n_pass++;
`endif
    do_write(8'h10, 8'h77, r, e, b1, zo, io);
    n_total++; if (e !== 1'b0) $display("FAIL prot_limit_err: got %b exp 0", e); else n_pass++;
    do_read(8'h10, 8'h10, lat, rd, bo, zo, io);
    n_total++; if (rd !== 8'h77) $display("FAIL prot_limit_data: got %h exp 77", rd); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_busy_ignore();
    test_latched_addr();
    test_back_to_back();
    test_reset_mid_read();
    test_protect();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
